cdc_reset_clear_agent: RTL and testbench

//  Subsystem-side responder for the isolate/clear handshake driven by the CDC reset controller.

---
 rtl/cdc_reset_clear_agent_if.sv | 30 +++
 rtl/cdc_reset_clear_agent.sv | 184 ++++++++++++++++++
 tb/tb_cdc_reset_clear_agent.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_reset_clear_agent_if.sv
// Request/response handshake between the upstream port, the clear agent and the
// downstream subsystem.
//   up_valid / up_ready : upstream request handshake
//   dn_valid / dn_ready : downstream request handshake
//   dn_rsp              : one-cycle pulse, one outstanding downstream request completed
// master: environment side (drives upstream requests, downstream ready/response)
// slave : agent side (forwards requests downstream, returns upstream ready)
interface cdc_reset_clear_agent_if;
    logic up_valid;
    logic up_ready;
    logic dn_valid;
    logic dn_ready;
    logic dn_rsp;

    modport master (
        output up_valid,
        output dn_ready,
        output dn_rsp,
        input  up_ready,
        input  dn_valid
    );

    modport slave (
        input  up_valid,
        input  dn_ready,
        input  dn_rsp,
        output up_ready,
        output dn_valid
    );
endinterface

// File: rtl/cdc_reset_clear_agent.sv
// Subsystem-side responder for the isolate/clear handshake of the CDC reset controller.
// On isolate it closes the request gate, drains outstanding downstream requests and acks;
// on clear it holds clear_rst_no low for CLEAR_CYCLES cycles and then acks.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   isolate_i       isolate request (level)     isolate_ack_o  isolation reached (level)
//   clear_i         clear request (level)       clear_ack_o    clear completed (level)
//   bus (slave)     up_valid/up_ready, dn_valid/dn_ready, dn_rsp
//   clear_rst_no    synchronous clear to subsystem, active-low
//   timeout_o       sticky drain-timeout flag
// Optional feature: define CDC_CLEAR_AGENT_TIMEOUT_EN to bound the drain to
// TIMEOUT_CYCLES cycles; otherwise the drain waits indefinitely and timeout_o is 0.
module cdc_reset_clear_agent #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CLEAR_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          isolate_i,
    output logic                          isolate_ack_o,
    input  logic                          clear_i,
    output logic                          clear_ack_o,
    cdc_reset_clear_agent_if.slave        bus,
    output logic                          clear_rst_no,
    output logic                          timeout_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_ISOLATED = 3'd2,
        ST_CLEARING = 3'd3,
        ST_CLEARED  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   out_q, out_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               isolate_ack_q;
    logic               clear_ack_q;
    logic               clear_rst_n_q;

    logic pass_c;
    logic accept_c;
    logic dec_c;

`ifdef CDC_CLEAR_AGENT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^32'(TIMEOUT_CYCLES);
`endif

    // Request gate: open only when idle, not being isolated, and below the outstanding limit.
    assign pass_c       = (state_q == ST_IDLE) && !isolate_i && (out_q < CNT_MAX);
    assign bus.dn_valid = bus.up_valid & pass_c;
    assign bus.up_ready = bus.dn_ready & pass_c;
    assign accept_c     = bus.up_valid & bus.dn_ready & pass_c;
    // Responses with nothing outstanding are ignored rather than wrapping the counter.
    assign dec_c        = bus.dn_rsp & (out_q != '0);

    // Next-state, outstanding counter and clear/timeout counters.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        clr_cnt_d = clr_cnt_q;
`ifdef CDC_CLEAR_AGENT_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
`endif
        if (accept_c && !dec_c) begin
            out_d = out_q + CNT_W'(1);
        end else if (!accept_c && dec_c) begin
            out_d = out_q - CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
`ifdef CDC_CLEAR_AGENT_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                if (isolate_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // out_d already includes a response arriving this cycle.
                if (!isolate_i) begin
                    state_d = ST_IDLE;
                end else if (out_d == '0) begin
                    state_d = ST_ISOLATED;
                end
`ifdef CDC_CLEAR_AGENT_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = ST_ISOLATED;
                    out_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            ST_ISOLATED: begin
                if (clear_i) begin
                    state_d   = ST_CLEARING;
                    clr_cnt_d = CLR_LOAD;
                end else if (!isolate_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEARING: begin
                // The clear window always runs to completion once started.
                out_d = '0;
                if (clr_cnt_q <= CLR_W'(1)) begin
                    state_d = ST_CLEARED;
`ifdef CDC_CLEAR_AGENT_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end else begin
                    clr_cnt_d = clr_cnt_q - CLR_W'(1);
                end
            end
            ST_CLEARED: begin
                if (!clear_i) begin
                    state_d = isolate_i ? ST_ISOLATED : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, decoded from the next state so they track it with one edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            out_q         <= '0;
            clr_cnt_q     <= '0;
            isolate_ack_q <= 1'b0;
            clear_ack_q   <= 1'b0;
            clear_rst_n_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            out_q         <= out_d;
            clr_cnt_q     <= clr_cnt_d;
            isolate_ack_q <= (state_d == ST_ISOLATED) || (state_d == ST_CLEARING) ||
                             (state_d == ST_CLEARED);
            clear_ack_q   <= (state_d == ST_CLEARED);
            clear_rst_n_q <= (state_d != ST_CLEARING);
        end
    end

`ifdef CDC_CLEAR_AGENT_TIMEOUT_EN
    // Drain timeout counter and sticky flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign isolate_ack_o = isolate_ack_q;
    assign clear_ack_o   = clear_ack_q;
    assign clear_rst_no  = clear_rst_n_q;

endmodule

// File: tb/tb_cdc_reset_clear_agent.sv
// Directed bench for cdc_reset_clear_agent: a per-cycle vector table for the main
// isolate/drain/clear/reset flows, plus hand sequences for the outstanding limit
// (second instance with MAX_OUTSTANDING=2) and the drain timeout.
module tb_cdc_reset_clear_agent;

`ifdef CDC_CLEAR_AGENT_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    typedef struct {
        logic rst_n, iso, clr, uv, dr, rsp;
        logic ur, dv, ack, cack, crn, tmo;
    } vec_t;

    logic clk;
    logic rst_n;
    logic iso, clr;
    logic ack, cack, crn, tmo;
    logic iso2, clr2;
    logic ack2, cack2, crn2, tmo2;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];

    cdc_reset_clear_agent_if bus ();
    cdc_reset_clear_agent_if bus2 ();

    cdc_reset_clear_agent #(
        .MAX_OUTSTANDING (8),
        .CLEAR_CYCLES    (4),
        .TIMEOUT_CYCLES  (16)
    ) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .isolate_i     (iso),
        .isolate_ack_o (ack),
        .clear_i       (clr),
        .clear_ack_o   (cack),
        .bus           (bus.slave),
        .clear_rst_no  (crn),
        .timeout_o     (tmo)
    );

    cdc_reset_clear_agent #(
        .MAX_OUTSTANDING (2),
        .CLEAR_CYCLES    (4),
        .TIMEOUT_CYCLES  (16)
    ) u_dut_m2 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .isolate_i     (iso2),
        .isolate_ack_o (ack2),
        .clear_i       (clr2),
        .clear_ack_o   (cack2),
        .bus           (bus2.slave),
        .clear_rst_no  (crn2),
        .timeout_o     (tmo2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic i, input logic c, input logic uv,
                       input logic dr, input logic rs, input logic eur, input logic edv,
                       input logic eack, input logic ecack, input logic ecrn, input logic etmo);
        vec_t v;
        v.rst_n = r;  v.iso = i;  v.clr = c;  v.uv = uv;  v.dr = dr;  v.rsp = rs;
        v.ur = eur;   v.dv = edv; v.ack = eack; v.cack = ecack; v.crn = ecrn; v.tmo = etmo;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs on the main instance, check at the falling edge, advance.
    task automatic apply(input vec_t v, input string tag);
        rst_n        = v.rst_n;
        iso          = v.iso;
        clr          = v.clr;
        bus.up_valid = v.uv;
        bus.dn_ready = v.dr;
        bus.dn_rsp   = v.rsp;
        @(negedge clk);
        chk({tag, ".up_ready"},    bus.up_ready, v.ur);
        chk({tag, ".dn_valid"},    bus.dn_valid, v.dv);
        chk({tag, ".isolate_ack"}, ack,          v.ack);
        chk({tag, ".clear_ack"},   cack,         v.cack);
        chk({tag, ".clear_rst_n"}, crn,          v.crn);
        chk({tag, ".timeout"},     tmo,          v.tmo);
        @(posedge clk);
        #1;
    endtask

    task automatic row(input string tag, input logic i, input logic c, input logic uv,
                       input logic dr, input logic rs, input logic eur, input logic edv,
                       input logic eack, input logic ecack, input logic ecrn, input logic etmo);
        vec_t v;
        v.rst_n = 1'b1; v.iso = i; v.clr = c; v.uv = uv; v.dr = dr; v.rsp = rs;
        v.ur = eur; v.dv = edv; v.ack = eack; v.cack = ecack; v.crn = ecrn; v.tmo = etmo;
        apply(v, tag);
    endtask

    // One cycle on the MAX_OUTSTANDING=2 instance.
    task automatic step2(input string tag, input logic uv, input logic dr, input logic rs,
                         input logic eur, input logic edv);
        bus2.up_valid = uv;
        bus2.dn_ready = dr;
        bus2.dn_rsp   = rs;
        @(negedge clk);
        chk({tag, ".up_ready"}, bus2.up_ready, eur);
        chk({tag, ".dn_valid"}, bus2.dn_valid, edv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        iso = 1'b0; clr = 1'b0;
        iso2 = 1'b0; clr2 = 1'b0;
        bus.up_valid = 1'b0;  bus.dn_ready = 1'b0;  bus.dn_rsp = 1'b0;
        bus2.up_valid = 1'b0; bus2.dn_ready = 1'b0; bus2.dn_rsp = 1'b0;

        //  rst iso clr uv dr rsp | ur dv ack cack crn tmo
        // three transfers, isolate closes the gate at once, ack after the last response
        add(1,0,0,1,1,0, 1,1,0,0,1,0);
        add(1,0,0,1,1,0, 1,1,0,0,1,0);
        add(1,0,0,1,1,0, 1,1,0,0,1,0);
        add(1,1,0,1,1,0, 0,0,0,0,1,0);
        add(1,1,0,1,1,1, 0,0,0,0,1,0);
        add(1,1,0,0,0,1, 0,0,0,0,1,0);
        add(1,1,0,0,0,1, 0,0,0,0,1,0);
        add(1,1,0,0,0,0, 0,0,1,0,1,0);
        // clear window: clear_rst_n low exactly 4 cycles, then clear_ack
        add(1,1,1,0,0,0, 0,0,1,0,1,0);
        add(1,1,1,0,0,0, 0,0,1,0,0,0);
        add(1,1,1,0,0,0, 0,0,1,0,0,0);
        add(1,1,1,0,0,0, 0,0,1,0,0,0);
        add(1,1,1,0,0,0, 0,0,1,0,0,0);
        add(1,1,1,0,0,0, 0,0,1,1,1,0);
        add(1,1,0,0,0,0, 0,0,1,1,1,0);
        add(1,1,0,0,0,0, 0,0,1,0,1,0);
        add(1,0,0,1,1,0, 0,0,1,0,1,0);
        add(1,0,0,0,1,0, 1,0,0,0,1,0);
        // spurious response at zero outstanding, then isolation still completes in 2 edges
        add(1,0,0,0,1,1, 1,0,0,0,1,0);
        add(1,1,0,0,1,0, 0,0,0,0,1,0);
        add(1,1,0,0,0,0, 0,0,0,0,1,0);
        add(1,1,1,0,0,0, 0,0,1,0,1,0);
        add(1,1,1,0,0,0, 0,0,1,0,0,0);
        // reset in the middle of the clear window
        add(0,1,1,0,0,0, 0,0,1,0,0,0);
        add(1,0,0,0,1,0, 1,0,0,0,1,0);
        // clear dropped early: window still completes, then back to isolated
        add(1,1,0,0,1,0, 0,0,0,0,1,0);
        add(1,1,0,0,0,0, 0,0,0,0,1,0);
        add(1,1,1,0,0,0, 0,0,1,0,1,0);
        add(1,1,0,0,0,0, 0,0,1,0,0,0);
        add(1,1,0,0,0,0, 0,0,1,0,0,0);
        add(1,1,0,0,0,0, 0,0,1,0,0,0);
        add(1,1,0,0,0,0, 0,0,1,0,0,0);
        add(1,1,0,0,0,0, 0,0,1,1,1,0);
        add(1,0,0,0,0,0, 0,0,1,0,1,0);
        add(1,0,0,0,1,0, 1,0,0,0,1,0);
        // clear raised together with isolate is held off until isolated
        add(1,1,1,0,0,0, 0,0,0,0,1,0);
        add(1,1,1,0,0,0, 0,0,0,0,1,0);
        add(1,1,1,0,0,0, 0,0,1,0,1,0);
        add(1,1,1,0,0,0, 0,0,1,0,0,0);
        add(1,1,1,0,0,0, 0,0,1,0,0,0);
        add(1,1,1,0,0,0, 0,0,1,0,0,0);
        add(1,1,1,0,0,0, 0,0,1,0,0,0);
        // both requests drop in CLEARED -> straight to idle
        add(1,0,0,0,1,0, 0,0,1,1,1,0);
        add(1,0,0,0,1,0, 1,0,0,0,1,0);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset values of the second instance
        @(negedge clk);
        chk("m2.reset.isolate_ack", ack2,  1'b0);
        chk("m2.reset.clear_ack",   cack2, 1'b0);
        chk("m2.reset.clear_rst_n", crn2,  1'b1);
        chk("m2.reset.timeout",     tmo2,  1'b0);
        @(posedge clk);
        #1;

        // outstanding limit of 2; accept and response together keep the count
        step2("m2.c0", 1, 1, 0, 1, 1);
        step2("m2.c1", 1, 1, 0, 1, 1);
        step2("m2.c2", 1, 1, 0, 0, 0);
        step2("m2.c3", 0, 1, 1, 0, 0);
        step2("m2.c4", 1, 1, 1, 1, 1);
        step2("m2.c5", 1, 1, 0, 1, 1);
        step2("m2.c6", 1, 1, 0, 0, 0);
        step2("m2.c7", 0, 1, 1, 0, 0);
        step2("m2.c8", 0, 1, 1, 1, 0);
        step2("m2.c9", 0, 1, 0, 1, 0);

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // drain timeout: one request never answered
        row("t.acc", 0,0,1,1,0, 1,1,0,0,1,0);
        row("t.iso", 1,0,0,1,0, 0,0,0,0,1,0);
        for (int k = 0; k < 16; k++) begin
            row($sformatf("t.drain%0d", k), 1,0,0,0,0, 0,0,0,0,1,0);
        end
        row("t.end", 1,0,0,0,0, 0,0,TMO_EN,0,1,TMO_EN);
        if (TMO_EN) begin
            // completing a clear window clears the sticky flag
            row("t.clr",  1,1,0,0,0, 0,0,1,0,1,1);
            for (int k = 0; k < 4; k++) begin
                row($sformatf("t.clring%0d", k), 1,1,0,0,0, 0,0,1,0,0,1);
            end
            row("t.cleared", 0,0,0,1,0, 0,0,1,1,1,0);
            row("t.idle",    0,0,0,1,0, 1,0,0,0,1,0);
        end else begin
            for (int k = 0; k < 30; k++) begin
                row($sformatf("t.wait%0d", k), 1,0,0,0,0, 0,0,0,0,1,0);
            end
            row("t.drop", 0,0,0,1,1, 0,0,0,0,1,0);
            row("t.idle", 0,0,0,1,0, 1,0,0,0,1,0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
